dds_sweep_ctrl: RTL

Sequencing controller for the sine DDS datapath. It accepts one sweep command at a time through a valid/ready handshake and drives the phase accumulator's increment, enable and clear. It watches the accumulator's 8-bit phase to count completed output periods, and steps the frequency word from a start value to a stop value. It sits between the lab's command source (switches/UART/testbench) and the phase accumulator feeding the sine LUT.

---
 rtl/dds_sweep_ctrl_if.sv | 28 ++
 rtl/dds_sweep_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// rtl/dds_sweep_ctrl_if.sv - sweep command handshake bundle between command source and controller
//   cmd_valid/cmd_ready : command handshake, transfer when both high
//   cmd_f_start/stop    : first and last phase increment of the sweep
//   cmd_f_delta         : frequency step size (0 = single jump to f_stop)
//   cmd_periods         : output periods per frequency step (0 = 1)
//   cmd_abort           : terminate a running sweep
interface dds_sweep_ctrl_if #(
  parameter int PW = 8,
  parameter int CW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [PW-1:0] cmd_f_start;
  logic [PW-1:0] cmd_f_stop;
  logic [PW-1:0] cmd_f_delta;
  logic [CW-1:0] cmd_periods;
  logic          cmd_abort;

  modport master (
    output cmd_valid, cmd_f_start, cmd_f_stop, cmd_f_delta, cmd_periods, cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_f_start, cmd_f_stop, cmd_f_delta, cmd_periods, cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - DDS frequency sweep sequencer driving the phase accumulator
//   clk, rst   : clock, synchronous active-low reset
//   cmd        : sweep command bundle (slave side)
//   phase      : accumulator phase, watched for wraps to count output periods
//   dds_en     : accumulator advance enable
//   dds_clr    : one-cycle accumulator clear at sweep start
//   dds_inc    : current phase increment (frequency word)
//   busy       : sweep running
//   done       : one-cycle completion pulse
//   status     : with done: 00 normal, 01 aborted, 10 rejected
module dds_sweep_ctrl #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dds_sweep_ctrl_if.slave       cmd,
  input  logic [PW-1:0]         phase,
  output logic                  dds_en,
  output logic                  dds_clr,
  output logic [PW-1:0]         dds_inc,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_ABORT  = 2'b01;
  localparam logic [1:0] ST_REJECT = 2'b10;

  logic [1:0]    state;
  logic [PW-1:0] f_stop_q;
  logic [PW-1:0] f_delta_q;
  logic [PW-1:0] phase_prev;
  logic [CW-1:0] periods_q;
  logic [CW-1:0] cnt;
  logic          up_q;
  logic          clr_d;

  logic          accept;
  logic          reject;
  logic [PW-1:0] delta_eff;
  logic [CW-1:0] periods_eff;

  logic          wrap;
  logic          step_done;
  logic          last_step;
  logic [PW:0]   sum_up;
  logic [PW:0]   diff_dn;
  logic [PW-1:0] next_f;

  assign cmd.cmd_ready = (state == S_IDLE) && rst;

  // Command decode at accept time. A zero delta becomes the full distance
  // so the sweep is a single jump from f_start to f_stop.
  always_comb begin
    accept      = cmd.cmd_valid && cmd.cmd_ready;
    reject      = (cmd.cmd_f_start == '0) || (cmd.cmd_f_stop == '0);
    delta_eff   = cmd.cmd_f_delta;
    if (cmd.cmd_f_delta == '0) begin
      delta_eff = (cmd.cmd_f_stop >= cmd.cmd_f_start) ? (cmd.cmd_f_stop - cmd.cmd_f_start)
                                                      : (cmd.cmd_f_start - cmd.cmd_f_stop);
    end
    periods_eff = (cmd.cmd_periods == '0) ? CW'(1) : cmd.cmd_periods;
  end

  // Period counting and next-frequency computation.
  // The clear cycle and the one after it are masked: the phase seen then
  // may still be stale relative to phase_prev depending on accumulator latency.
  always_comb begin
    wrap      = (state == S_RUN) && !dds_clr && !clr_d && (phase < phase_prev);
    step_done = wrap && ((cnt + CW'(1)) == periods_q);
    last_step = (dds_inc == f_stop_q);
    sum_up    = {1'b0, dds_inc} + {1'b0, f_delta_q};
    diff_dn   = {1'b0, dds_inc} - {1'b0, f_delta_q};
    next_f    = up_q ? sum_up[PW-1:0] : diff_dn[PW-1:0];
    // Overshoot of f_stop, overflow past 2^PW-1, or landing on/below zero
    // all clamp to f_stop (f_stop is never zero for a running sweep).
    if (up_q) begin
      if (sum_up > {1'b0, f_stop_q}) next_f = f_stop_q;
    end else begin
      if (diff_dn[PW] || (diff_dn < {1'b0, f_stop_q})) next_f = f_stop_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      dds_en     <= 1'b0;
      dds_clr    <= 1'b0;
      dds_inc    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= ST_OK;
      cnt        <= '0;
      phase_prev <= '0;
      clr_d      <= 1'b0;
      f_stop_q   <= '0;
      f_delta_q  <= '0;
      periods_q  <= '0;
      up_q       <= 1'b0;
    end else begin
      phase_prev <= phase;
      clr_d      <= dds_clr;
      case (state)
        S_IDLE: begin
          if (accept) begin
            f_stop_q  <= cmd.cmd_f_stop;
            f_delta_q <= delta_eff;
            periods_q <= periods_eff;
            up_q      <= (cmd.cmd_f_stop >= cmd.cmd_f_start);
            cnt       <= '0;
            if (reject) begin
              state  <= S_DONE;
              done   <= 1'b1;
              status <= ST_REJECT;
            end else begin
              state   <= S_RUN;
              busy    <= 1'b1;
              dds_en  <= 1'b1;
              dds_clr <= 1'b1;
              dds_inc <= cmd.cmd_f_start;
            end
          end
        end
        S_RUN: begin
          dds_clr <= 1'b0;
          // Abort takes priority over a final wrap in the same cycle.
          if (cmd.cmd_abort || (step_done && last_step)) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            dds_en <= 1'b0;
            done   <= 1'b1;
            status <= cmd.cmd_abort ? ST_ABORT : ST_OK;
          end else if (wrap) begin
            if (step_done) begin
              cnt     <= '0;
              dds_inc <= next_f;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
